// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg -- shared types and defaults for the UART receiver slice.
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 10416;
  localparam int PACKET_LEN_DEFAULT   = 50;
  localparam int FRAME_BITS           = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// uart_rx_sync -- two-flop synchronizer for the serial line, idles high.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// uart_receiver -- 8N1 UART receiver with ready/valid holding register,
// sticky frame/overrun flags and packet byte counter.
// Optional build macro: UART_RX_MAJORITY_EN (2-of-3 vote per sample).
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PACKET_LEN   = PACKET_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [7:0] rx_count,
  input  logic       clear_err
);

  localparam int            TW   = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic          rxd_s;
  uart_state_e   state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          armed_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;
  logic [7:0]    rx_count_q;

  logic          bit_d;
  logic          decide_d;
  logic          stop_ok_d;
  logic          stop_bad_d;
  logic          accept_d;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (rxd),
    .sync_o  (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Votes span mid-1..mid+1; the start decision is one cycle late, which also
  // shifts every later decision so the window stays centred on each bit.
  localparam logic [TW-1:0] START_DEC = TW'(CLKS_PER_BIT / 2 + 1);
  logic [1:0] vote_q;

  always_ff @(posedge clk) begin
    if (reset) vote_q <= 2'b11;
    else       vote_q <= {vote_q[0], rxd_s};
  end

  assign bit_d = (vote_q[0] & vote_q[1]) | (rxd_s & (vote_q[0] | vote_q[1]));
`else
  localparam logic [TW-1:0] START_DEC = TW'(CLKS_PER_BIT / 2);
  assign bit_d = rxd_s;
`endif

  assign decide_d   = (timer_q == ((state_q == START) ? START_DEC : LAST));
  assign stop_ok_d  = (state_q == STOP) && decide_d && bit_d;
  assign stop_bad_d = (state_q == STOP) && decide_d && !bit_d;
  assign accept_d   = rx_valid_q && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (rxd_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (decide_d) begin
            timer_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= bit_d ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        DATA: begin
          if (decide_d) begin
            timer_q   <= '0;
            shift_q   <= {bit_d, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(FRAME_BITS - 3)) state_q <= STOP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        STOP: begin
          if (decide_d) begin
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (stop_ok_d && (!rx_valid_q || rx_ready)) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (accept_d) begin
        rx_valid_q <= 1'b0;
      end

      if (accept_d)
        rx_count_q <= (rx_count_q == 8'(PACKET_LEN - 1)) ? 8'd0 : rx_count_q + 8'd1;

      if (stop_bad_d)     frame_err_q <= 1'b1;
      else if (clear_err) frame_err_q <= 1'b0;

      if (stop_ok_d && rx_valid_q && !rx_ready) overrun_q <= 1'b1;
      else if (clear_err)                       overrun_q <= 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_count  = rx_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// tb_uart_receiver -- scoreboard bench: stimulus queues expected bytes, a
// negedge monitor pops them on every accepted handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int PLEN = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [7:0] rx_count;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         mdl_count = 0;
  bit         cnt_pend = 0;
  int         n_accept = 0;
  int         n_good = 0;
  bit         mdl_ferr = 0;
  int         base;
  logic [7:0] rb;
  bit         bad;

  always #5 clk = ~clk;

  uart_receiver #(.CLKS_PER_BIT(CPB), .PACKET_LEN(PLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_count  (rx_count),
    .clear_err (clear_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: start, 8 data LSB-first, stop; optional single-cycle inversion
  // at (sp_bit, sp_off) within the frame.
  task automatic send_frame(input logic [7:0] b, input logic stopb,
                            input int sp_bit, input int sp_off);
    logic [FRAME_BITS-1:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < FRAME_BITS; i++) begin
      for (int c = 0; c < CPB; c++) begin
        rxd = (i == sp_bit && c == sp_off) ? ~fr[i] : fr[i];
        tick(1);
      end
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"},  rx_valid,  0);
    check({tag, "_rx_data"},   rx_data,   0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"},   overrun,   0);
    check({tag, "_rx_count"},  rx_count,  0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mdl_count = 0;
      cnt_pend  = 0;
    end else begin
      if (cnt_pend) begin
        check("rx_count_after_accept", rx_count, mdl_count);
        cnt_pend = 0;
      end
      if (rx_valid && rx_ready) begin
        n_accept++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", rx_data);
        end else begin
          exp_b = sb.pop_front();
          check("rx_data", rx_data, exp_b);
        end
        mdl_count = (mdl_count + 1) % PLEN;
        cnt_pend  = 1;
      end
    end
  end

  initial begin
    reset = 1'b1;
    tick(4);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    tick(2);
    check_reset_outputs("post_reset");

    // Single clean frame
    base = n_accept;
    sb.push_back(8'hA5);
    n_good++;
    send_frame(8'hA5, 1'b1, -1, -1);
    tick(3 * CPB);
    check("a5_accepts", n_accept - base, 1);
    check("a5_frame_err", frame_err, 0);
    check("a5_rx_count", rx_count, n_good % PLEN);
    check("a5_sb_drained", sb.size(), 0);

    // Short low glitch must be rejected, then a normal frame still works
    base = n_accept;
    rxd = 1'b0;
    tick(3);
    rxd = 1'b1;
    tick(3 * CPB);
    check("glitch_accepts", n_accept - base, 0);
    check("glitch_frame_err", frame_err, 0);
    check("glitch_overrun", overrun, 0);
    sb.push_back(8'hC3);
    n_good++;
    send_frame(8'hC3, 1'b1, 4, 2);
    tick(2 * CPB);
    check("post_glitch_accepts", n_accept - base, 1);

    // Bad stop bit
    base = n_accept;
    send_frame(8'h3C, 1'b0, -1, -1);
    tick(2 * CPB);
    check("ferr_set", frame_err, 1);
    check("ferr_rx_valid", rx_valid, 0);
    check("ferr_accepts", n_accept - base, 0);
    pulse_clear();
    check("ferr_cleared", frame_err, 0);

    // Overrun with consumer stalled
    rx_ready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    tick(CPB);
    send_frame(8'h22, 1'b1, -1, -1);
    tick(2 * CPB);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data_held", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    rx_ready = 1'b1;
    n_good++;
    tick(4);
    check("ovr_rx_valid_cleared", rx_valid, 0);
    check("ovr_rx_count", rx_count, n_good % PLEN);
    check("ovr_sb_drained", sb.size(), 0);
    pulse_clear();
    check("ovr_cleared", overrun, 0);

`ifdef UART_RX_MAJORITY_EN
    // Spike exactly at the centre sample of data bit 3 is outvoted
    sb.push_back(8'h5A);
    n_good++;
    send_frame(8'h5A, 1'b1, 4, 9);
    tick(2 * CPB);
    check("maj_sb_drained", sb.size(), 0);
`endif

    // Randomised traffic; a few early frames carry a bad stop bit
    for (int i = 0; i < 60; i++) begin
      rb  = 8'($urandom);
      bad = (i < 8) && ($urandom_range(0, 3) == 0);
      if (bad) begin
        mdl_ferr = 1;
      end else begin
        sb.push_back(rb);
        n_good++;
      end
      send_frame(rb, ~bad, -1, -1);
      tick($urandom_range(4, 20));
    end
    tick(2 * CPB);
    check("rand_sb_drained", sb.size(), 0);
    check("rand_frame_err", frame_err, mdl_ferr);
    check("rand_overrun", overrun, 0);
    check("rand_rx_count_wrapped", rx_count, n_good % PLEN);
    pulse_clear();

    // Reset in the middle of the data bits of a further frame
    for (int c = 0; c < 4 * CPB; c++) begin
      rxd = (c < CPB) ? 1'b0 : ((c / CPB) % 2 == 1);
      tick(1);
    end
    reset = 1'b1;
    rxd   = 1'b1;
    tick(3);
    reset = 1'b0;
    sb.delete();
    n_good = 0;
    tick(1);
    check_reset_outputs("midframe_reset");
    base = n_accept;
    tick(3 * CPB);
    check("midframe_no_accept", n_accept - base, 0);
    check("midframe_no_ferr", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
